// File: rtl/pa_f_sram_ctrl.sv
// pa_f_sram_ctrl: single-port SRAM controller with zero-fill init,
// valid/ready request port and a 2-entry registered read-response FIFO.
module pa_f_sram_ctrl #(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 32,
   parameter bit INIT_EN    = 1'b1
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    req_vld,
   output logic                    req_rdy,
   input  logic                    req_wr,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_be,
   output logic                    rsp_vld,
   input  logic                    rsp_rdy,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    init_done,
   output logic [ADDR_WIDTH-1:0]   sram_a,
   output logic                    sram_cen,
   output logic                    sram_gwen,
   output logic [DATA_WIDTH-1:0]   sram_wen,
   output logic [DATA_WIDTH-1:0]   sram_d,
   input  logic [DATA_WIDTH-1:0]   sram_q
);

   localparam int BE_WIDTH = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_t;

   state_t                  state_q;
   state_t                  state_d;
   logic [ADDR_WIDTH-1:0]   cnt_q;
   logic                    init_done_q;
   logic                    rd_pend_q;
   logic                    head_vld_q;
   logic                    tail_vld_q;
   logic [DATA_WIDTH-1:0]   head_q;
   logic [DATA_WIDTH-1:0]   tail_q;
   logic [1:0]              occ;
   logic                    accept;
   logic                    rd_acc;
   logic                    wr_acc;
   logic                    push;
   logic                    pop;

   // Credit check uses registered state only; a same-cycle pop is not credited.
   always_comb begin
      occ     = {1'b0, head_vld_q} + {1'b0, tail_vld_q} + {1'b0, rd_pend_q};
      req_rdy = (state_q == ST_RUN) && (occ < 2'd2);
      accept  = req_vld && req_rdy;
      rd_acc  = accept && !req_wr;
      wr_acc  = accept && req_wr;
      push    = rd_pend_q;
      pop     = head_vld_q && rsp_rdy;
   end

   // Next-state logic: leave INIT after the last address (or at once without init).
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_INIT: begin
            if (!INIT_EN || cnt_q == CNT_LAST) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   // State register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_INIT;
      end else begin
         state_q <= state_d;
      end
   end

   // Init address walker; freezes once the last word has been cleared.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q <= '0;
      end else if (state_q == ST_INIT && cnt_q != CNT_LAST) begin
         cnt_q <= cnt_q + ADDR_WIDTH'(1);
      end
   end

   // init_done follows the state register so it rises with entry to RUN.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         init_done_q <= 1'b0;
      end else begin
         init_done_q <= (state_d == ST_RUN);
      end
   end

   // SRAM port: zero-fill during init, pass-through access in RUN, idle otherwise.
   always_comb begin
      sram_a    = req_addr;
      sram_d    = req_wdata;
      sram_cen  = 1'b1;
      sram_gwen = 1'b1;
      sram_wen  = '1;
      if (state_q == ST_INIT) begin
         if (INIT_EN && !RST) begin
            sram_a    = cnt_q;
            sram_d    = '0;
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
         end
      end else if (rd_acc) begin
         sram_cen = 1'b0;
      end else if (wr_acc && (|req_be)) begin
         sram_cen  = 1'b0;
         sram_gwen = 1'b0;
         for (int b = 0; b < BE_WIDTH; b++) begin
            sram_wen[8*b +: 8] = {8{~req_be[b]}};
         end
      end
   end

   // Read-in-flight flag: set by an accepted read, consumed the next edge.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rd_pend_q <= 1'b0;
      end else begin
         rd_pend_q <= rd_acc;
      end
   end

   // Two-entry in-order response FIFO; the head register drives the outputs.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         head_vld_q <= 1'b0;
         tail_vld_q <= 1'b0;
         head_q     <= '0;
         tail_q     <= '0;
      end else if (pop) begin
         if (tail_vld_q) begin
            head_q <= tail_q;
            if (push) begin
               tail_q <= sram_q;
            end else begin
               tail_vld_q <= 1'b0;
            end
         end else if (push) begin
            head_q <= sram_q;
         end else begin
            head_vld_q <= 1'b0;
         end
      end else if (push) begin
         if (!head_vld_q) begin
            head_q     <= sram_q;
            head_vld_q <= 1'b1;
         end else begin
            tail_q     <= sram_q;
            tail_vld_q <= 1'b1;
         end
      end
   end

   assign rsp_vld   = head_vld_q;
   assign rsp_rdata = head_q;
   assign init_done = init_done_q;

endmodule

// File: tb/tb_pa_f_sram_ctrl.sv
// tb_pa_f_sram_ctrl: directed vectors with a response scoreboard
// for pa_f_sram_ctrl, driving a behavioural SRAM model.
module tb_pa_f_sram_ctrl;

   localparam int AW = 11;
   localparam int DW = 32;
   localparam int BW = DW / 8;

   logic          CLK = 1'b0;
   logic          RST;
   logic          req_vld;
   logic          req_rdy;
   logic          req_wr;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [BW-1:0] req_be;
   logic          rsp_vld;
   logic          rsp_rdy;
   logic [DW-1:0] rsp_rdata;
   logic          init_done;
   logic [AW-1:0] sram_a;
   logic          sram_cen;
   logic          sram_gwen;
   logic [DW-1:0] sram_wen;
   logic [DW-1:0] sram_d;
   logic [DW-1:0] sram_q;

   logic [DW-1:0] mem [0:2**AW-1];
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] exp_v;
   int            vectors = 0;
   int            miscompares = 0;

   pa_f_sram_ctrl #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .INIT_EN(1'b1)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .req_vld(req_vld),
      .req_rdy(req_rdy),
      .req_wr(req_wr),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .req_be(req_be),
      .rsp_vld(rsp_vld),
      .rsp_rdy(rsp_rdy),
      .rsp_rdata(rsp_rdata),
      .init_done(init_done),
      .sram_a(sram_a),
      .sram_cen(sram_cen),
      .sram_gwen(sram_gwen),
      .sram_wen(sram_wen),
      .sram_d(sram_d),
      .sram_q(sram_q)
   );

   always #5 CLK = ~CLK;

   // SRAM model: per-bit active-low write mask, read data the cycle after.
   always @(posedge CLK) begin
      if (!sram_cen) begin
         if (!sram_gwen) begin
            mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
         end else begin
            sram_q <= mem[sram_a];
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // Monitor: every response handshake is matched against the scoreboard.
   always @(negedge CLK) begin
      if (!RST && rsp_vld && rsp_rdy) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_rsp: got %08h required none", rsp_rdata);
         end else begin
            exp_v = exp_q.pop_front();
            chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, exp_v});
         end
      end
   end

   task automatic do_req(input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input logic [BW-1:0] be,
                         input logic [DW-1:0] rexp);
      int budget;
      logic [DW-1:0] wen_exp;
      req_vld   = 1'b1;
      req_wr    = wr;
      req_addr  = addr;
      req_wdata = wd;
      req_be    = be;
      budget    = 0;
      @(negedge CLK);
      while (!req_rdy && budget < 200) begin
         @(posedge CLK);
         #1;
         @(negedge CLK);
         budget++;
      end
      if (!req_rdy) begin
         vectors++;
         miscompares++;
         $display("FAIL req_timeout: req_rdy 0 required 1 at addr %0h", addr);
      end else begin
         chk("sram_a", {53'd0, sram_a}, {53'd0, addr});
         if (!wr) begin
            chk("rd_cen", {63'd0, sram_cen}, 64'd0);
            chk("rd_gwen", {63'd0, sram_gwen}, 64'd1);
            exp_q.push_back(rexp);
         end else if (be == '0) begin
            chk("null_cen", {63'd0, sram_cen}, 64'd1);
         end else begin
            for (int b = 0; b < BW; b++) begin
               wen_exp[8*b +: 8] = be[b] ? 8'h00 : 8'hFF;
            end
            chk("wr_cen", {63'd0, sram_cen}, 64'd0);
            chk("wr_gwen", {63'd0, sram_gwen}, 64'd0);
            chk("wr_wen", {32'd0, sram_wen}, {32'd0, wen_exp});
            chk("wr_d", {32'd0, sram_d}, {32'd0, wd});
         end
      end
      @(posedge CLK);
      #1;
      req_vld = 1'b0;
   endtask

   task automatic check_reset_outs();
      chk("rst_req_rdy", {63'd0, req_rdy}, 64'd0);
      chk("rst_rsp_vld", {63'd0, rsp_vld}, 64'd0);
      chk("rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
      chk("rst_init_done", {63'd0, init_done}, 64'd0);
      chk("rst_cen", {63'd0, sram_cen}, 64'd1);
      chk("rst_gwen", {63'd0, sram_gwen}, 64'd1);
      chk("rst_wen", {32'd0, sram_wen}, 64'h0000_0000_FFFF_FFFF);
   endtask

   task automatic wait_init();
      int n;
      n = 0;
      while (!init_done && n < 5000) begin
         @(posedge CLK);
         #1;
         n++;
         if (n == 5) begin
            chk("init_a", {53'd0, sram_a}, 64'd5);
            chk("init_cen", {63'd0, sram_cen}, 64'd0);
            chk("init_gwen", {63'd0, sram_gwen}, 64'd0);
            chk("init_wen", {32'd0, sram_wen}, 64'd0);
            chk("init_d", {32'd0, sram_d}, 64'd0);
            chk("init_rdy", {63'd0, req_rdy}, 64'd0);
         end
      end
      chk("init_cycles", 64'(n), 64'd2048);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      RST       = 1'b1;
      req_vld   = 1'b0;
      req_wr    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_be    = '0;
      rsp_rdy   = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      check_reset_outs();
      RST = 1'b0;
      wait_init();

      do_req(1'b0, 11'h7FF, 32'h0, 4'h0, 32'h0000_0000);

      do_req(1'b1, 11'h123, 32'hDEAD_BEEF, 4'b1111, 32'h0);
      do_req(1'b1, 11'h123, 32'h1122_3344, 4'b0101, 32'h0);
      do_req(1'b0, 11'h123, 32'h0, 4'h0, 32'hDE22_BE44);
      repeat (4) @(posedge CLK);
      #1;

      do_req(1'b1, 11'h010, 32'hA5A5_A5A5, 4'b1111, 32'h0);
      do_req(1'b0, 11'h010, 32'h0, 4'h0, 32'hA5A5_A5A5);
      @(negedge CLK);
      chk("raw_lat_n1", {63'd0, rsp_vld}, 64'd0);
      @(posedge CLK);
      #1;
      @(negedge CLK);
      chk("raw_lat_n2", {63'd0, rsp_vld}, 64'd1);
      @(posedge CLK);
      #1;

      do_req(1'b1, 11'h010, 32'hFFFF_FFFF, 4'b0000, 32'h0);
      do_req(1'b0, 11'h010, 32'h0, 4'h0, 32'hA5A5_A5A5);
      repeat (4) @(posedge CLK);
      #1;

      do_req(1'b1, 11'h020, 32'h0000_1111, 4'b1111, 32'h0);
      do_req(1'b1, 11'h021, 32'h2222_3333, 4'b1111, 32'h0);
      rsp_rdy = 1'b0;
      do_req(1'b0, 11'h020, 32'h0, 4'h0, 32'h0000_1111);
      do_req(1'b0, 11'h021, 32'h0, 4'h0, 32'h2222_3333);
      req_vld  = 1'b1;
      req_wr   = 1'b0;
      req_addr = 11'h7FF;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         chk("bp_rdy", {63'd0, req_rdy}, 64'd0);
         chk("bp_vld", {63'd0, rsp_vld}, 64'd1);
         chk("bp_hold", {32'd0, rsp_rdata}, 64'h0000_1111);
         @(posedge CLK);
         #1;
      end
      rsp_rdy = 1'b1;
      do_req(1'b0, 11'h7FF, 32'h0, 4'h0, 32'h0000_0000);
      repeat (6) @(posedge CLK);
      #1;
      chk("bp_drained", 64'(exp_q.size()), 64'd0);

      rsp_rdy = 1'b0;
      do_req(1'b0, 11'h123, 32'h0, 4'h0, 32'hDE22_BE44);
      do_req(1'b0, 11'h010, 32'h0, 4'h0, 32'hA5A5_A5A5);
      RST = 1'b1;
      #1;
      chk("midrst_rsp_vld", {63'd0, rsp_vld}, 64'd0);
      chk("midrst_req_rdy", {63'd0, req_rdy}, 64'd0);
      chk("midrst_init_done", {63'd0, init_done}, 64'd0);
      chk("midrst_cen", {63'd0, sram_cen}, 64'd1);
      exp_q.delete();
      rsp_rdy = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      wait_init();
      do_req(1'b0, 11'h123, 32'h0, 4'h0, 32'h0000_0000);
      repeat (6) @(posedge CLK);
      #1;
      chk("final_drained", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pa_f_sram_ctrl.md
PA_F_SRAM_CTRL -- requirements
Module: pa_f_sram_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: CLK (rising edge) and RST (RST=1 resets immediately, independent of CLK).
REQ-002 The block SHALL take parameters (name, default, meaning):
- ADDR_WIDTH, 11, word address width.
- DATA_WIDTH, 32, data width; must be a multiple of 8.
- INIT_EN, 1, zero-fill the SRAM after reset.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- CLK, in, 1, clock.
- RST, in, 1, async active-high reset.
- req_vld, in, 1, request valid.
- req_rdy, out, 1, request ready.
- req_wr, in, 1, 1=write, 0=read.
- req_addr, in, ADDR_WIDTH, word address.
- req_wdata, in, DATA_WIDTH, write data.
- req_be, in, DATA_WIDTH/8, byte enables.
- rsp_vld, out, 1, read response valid.
- rsp_rdy, in, 1, response ready.
- rsp_rdata, out, DATA_WIDTH, read data.
- init_done, out, 1, SRAM initialised and block accepting requests.
- sram_a, out, ADDR_WIDTH, SRAM address.
- sram_cen, out, 1, chip enable, active-low.
- sram_gwen, out, 1, global write enable, active-low.
- sram_wen, out, DATA_WIDTH, per-bit write enable, active-low.
- sram_d, out, DATA_WIDTH, SRAM write data.
- sram_q, in, DATA_WIDTH, SRAM read data, valid the cycle after a read access.

Function
REQ-004 The block SHALL implement a two-state FSM, INIT and RUN. Reset enters INIT. If INIT_EN=0, the block SHALL move to RUN on the first clock edge.
REQ-005 In INIT, a counter SHALL walk addresses 0 to 2^ADDR_WIDTH-1, one per cycle. Each cycle SHALL drive sram_cen=0, sram_gwen=0, sram_wen=all zeros, sram_d=0 and sram_a=counter.
REQ-006 On the cycle the counter equals 2^ADDR_WIDTH-1, the FSM SHALL move to RUN. init_done is registered and SHALL rise on the next edge, i.e. 2^ADDR_WIDTH cycles after reset release.
REQ-007 The counter SHALL NOT wrap or restart while the FSM is in RUN.
REQ-008 The block SHALL drive req_rdy=1 only when all of the following hold:
- the FSM is in RUN;
- response FIFO occupancy plus the read-in-flight flag is less than 2.
A response popped in the same cycle SHALL NOT be credited. req_rdy SHALL NOT depend on req_vld or req_wr.
REQ-009 A request is accepted when req_vld=1 and req_rdy=1. The SRAM access SHALL be issued combinationally in that same cycle, with sram_a=req_addr.
REQ-010 An accepted read SHALL drive sram_cen=0 and sram_gwen=1, and SHALL set the read-in-flight flag.
REQ-011 An accepted write with req_be non-zero SHALL drive:
- sram_cen=0 and sram_gwen=0;
- sram_wen[8b+7:8b]=~{8{req_be[b]}} for each byte b;
- sram_d=req_wdata.
REQ-012 An accepted write with req_be=0 SHALL be consumed with no SRAM access (sram_cen=1).
REQ-013 Writes SHALL produce no response.
REQ-014 When no access is issued, the block SHALL drive sram_cen=1, sram_gwen=1 and sram_wen=all ones.
REQ-015 In RUN, the block SHALL drive sram_a=req_addr and sram_d=req_wdata.
REQ-016 On the edge following a read access, the block SHALL push sram_q into a 2-entry in-order response FIFO and clear the in-flight flag.
REQ-017 rsp_vld SHALL equal FIFO non-empty, and rsp_rdata SHALL equal the FIFO head. Both are registered.
REQ-018 Read latency SHALL be: read accepted in cycle N, rsp_vld=1 in cycle N+2 at the earliest.
REQ-019 A response pops when rsp_vld=1 and rsp_rdy=1. A push and a pop in the same cycle SHALL leave occupancy unchanged and SHALL preserve order.
REQ-020 Back-to-back requests SHALL be serviced in order. A read of address X that follows a write to X in the previous cycle SHALL return the new data.
REQ-021 rsp_rdata SHALL hold its value while rsp_vld=1 and rsp_rdy=0.

Reset
REQ-022 While RST=1 the block SHALL drive:
- req_rdy=0, rsp_vld=0, rsp_rdata=0, init_done=0;
- sram_cen=1, sram_gwen=1, sram_wen=all ones.
REQ-023 RST asserted mid-operation SHALL immediately:
- clear the FIFO and the in-flight flag;
- return the FSM to INIT with counter=0.
No response from before reset SHALL ever appear afterwards.

Verification
REQ-024 Init: release RST with INIT_EN=1 -> init_done rises exactly 2048 cycles later. A subsequent read of 0x7FF SHALL return 0x00000000.
REQ-025 Byte enables:
- write 0x123 with 0xDEADBEEF, be=4'b1111;
- then write 0x123 with 0x11223344, be=4'b0101;
- then read 0x123 -> rsp_rdata=0xDE22BE44.
REQ-026 Backpressure: hold rsp_rdy=0 and present continuous reads -> exactly 2 are accepted and req_rdy stays 0. Raising rsp_rdy SHALL return both responses in order, and req_rdy SHALL reassert.
REQ-027 Read-after-write: write 0x010 with 0xA5A5A5A5, followed next cycle by a read of 0x010 -> the response is 0xA5A5A5A5 and rsp_vld rises 2 cycles after the read is accepted.
REQ-028 Null write: write with be=0 -> sram_cen stays 1 that cycle, and a later read returns the unchanged data.
REQ-029 Reset mid-read: assert RST one cycle after a read is accepted -> rsp_vld is 0 immediately, no stale response appears after release, and init_done reasserts after 2048 cycles.
